// File: rtl/spi_slave_only_rx_single_cs.sv
// Receive-only mode-0 SPI slave, oversampled in the clk_i domain; MSB-first frames to a parallel word + strobe.
// Optional SPI_RX_FRAME_ERROR_EN adds frame_error_o / error_count_o for aborted partial frames.
module spi_slave_only_rx_single_cs #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spi_clk_i,
  input  logic                  spi_mosi_i,
  input  logic                  spi_cs_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_strobe_o,
  output logic                  busy_o
`ifdef SPI_RX_FRAME_ERROR_EN
  ,
  output logic                  frame_error_o,
  output logic [7:0]            error_count_o
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_q;

  logic                   w_sclk_s;
  logic                   w_mosi_s;
  logic                   w_cs_s;
  logic                   w_rise;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [DATA_WIDTH-1:0]  r_shift;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_strobe;

  logic                   w_shift_en;
  logic                   w_done;
  logic                   w_cnt_clr;
  logic                   w_abort;
  logic [DATA_WIDTH-1:0]  w_shift_nxt;

  // All three pins share one stage count so data stays aligned with its clock edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_q    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_i};
      r_sclk_q    <= w_sclk_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_rise      = w_sclk_s & ~r_sclk_q;
  assign w_shift_nxt = {r_shift[DATA_WIDTH-2:0], w_mosi_s};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // CS deassert wins over a coincident rise, so that rise never reaches the shifter.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_done      = 1'b0;
    w_cnt_clr   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_cs_s) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_cs_s) begin
          w_state_nxt = IDLE;
          w_cnt_clr   = 1'b1;
          w_abort     = (r_cnt != '0);
        end else if (w_rise) begin
          w_shift_en = 1'b1;
          w_done     = (r_cnt == CNT_LAST);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_shift_en) begin
        r_cnt <= w_done ? '0 : r_cnt + 1'b1;
      end
      if (w_shift_en) begin
        r_shift <= w_shift_nxt;
      end
      if (w_done) begin
        r_data   <= w_shift_nxt;
        r_strobe <= 1'b1;
      end
    end
  end

  assign data_o              = r_data;
  assign data_valid_strobe_o = r_strobe;
  assign busy_o              = (r_state == SHIFT) && (r_cnt != '0);

`ifdef SPI_RX_FRAME_ERROR_EN
  logic       r_frame_error;
  logic [7:0] r_error_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_frame_error <= 1'b0;
      r_error_count <= '0;
    end else begin
      r_frame_error <= w_abort;
      if (w_abort && (r_error_count != 8'hFF)) begin
        r_error_count <= r_error_count + 8'd1;
      end
    end
  end

  assign frame_error_o = r_frame_error;
  assign error_count_o = r_error_count;
`else
  logic w_abort_unused;
  assign w_abort_unused = w_abort;
`endif

endmodule

// File: tb/tb_spi_slave_only_rx_single_cs.sv
// Bench for spi_slave_only_rx_single_cs: pin-level frame model plus per-cycle output compare.
// Builds with or without SPI_RX_FRAME_ERROR_EN.
module tb_spi_slave_only_rx_single_cs;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_cs = 1'b1;
  logic [7:0] data_o;
  logic       strobe;
  logic       busy;
`ifdef SPI_RX_FRAME_ERROR_EN
  logic       frame_error;
  logic [7:0] error_count;
`endif

  spi_slave_only_rx_single_cs #(.DATA_WIDTH(8), .SYNC_STAGES(SYNC)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .spi_clk_i          (spi_clk),
    .spi_mosi_i         (spi_mosi),
    .spi_cs_i           (spi_cs),
    .data_o             (data_o),
    .data_valid_strobe_o(strobe),
    .busy_o             (busy)
`ifdef SPI_RX_FRAME_ERROR_EN
    ,
    .frame_error_o      (frame_error),
    .error_count_o      (error_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       rst_q = 1'b1;
  exp_t       exp_q[$];
  int         err_due_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] model_data = 8'h00;
  logic [7:0] m_word = 8'h00;
  int         m_cnt = 0;
  int         m_err_cnt = 0;
  int         last_rise_cyc = 0;
  int         strobe_cyc = 0;
  int         err_pulses = 0;
  bit         hist [0:16383];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_i;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Pin-level frame assembly: every DATA_WIDTH rises under CS low make one word.
  task automatic rise_model();
    last_rise_cyc = cyc;
    if (!spi_cs && !rst_i) begin
      m_word = {m_word[6:0], spi_mosi};
      m_cnt++;
      if (m_cnt == 8) begin
        exp_q.push_back('{cyc + LAT, m_word});
        m_cnt = 0;
      end
    end
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
  endtask

  task automatic cs_high();
    spi_cs = 1'b1;
    if (m_cnt != 0 && !rst_i) begin
      err_due_q.push_back(cyc + LAT);
      if (m_err_cnt < 255) m_err_cnt++;
    end
    m_cnt = 0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input int h);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      wait_cyc(h);
      spi_clk = 1'b1;
      rise_model();
      wait_cyc(h);
      spi_clk = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    hist[cyc] = !spi_cs && (m_cnt != 0) && !rst_i;
    if (rst_q) begin
      check("rst_data", data_o, 0);
      check("rst_strobe", strobe, 0);
      check("rst_busy", busy, 0);
      model_data = 8'h00;
      exp_q.delete();
      err_due_q.delete();
    end else begin
      if (strobe) begin
        strobe_cyc = cyc;
        rx_q.push_back(data_o);
        checks++;
        if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
          errors++;
          $display("FAIL strobe_unexpected at cycle %0d data %0h", cyc, data_o);
        end else begin
          check("strobe_data", data_o, exp_q[0].data);
          model_data = exp_q[0].data;
          void'(exp_q.pop_front());
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL strobe_missing at cycle %0d: no strobe, expected data %0h", cyc, exp_q[0].data);
        model_data = exp_q[0].data;
        void'(exp_q.pop_front());
      end
      check("data_hold", data_o, model_data);
      if (cyc >= LAT) check("busy", busy, hist[cyc-LAT]);
`ifdef SPI_RX_FRAME_ERROR_EN
      if (frame_error) err_pulses++;
      if (err_due_q.size() != 0 && err_due_q[0] == cyc) begin
        check("frame_error", frame_error, 1);
        void'(err_due_q.pop_front());
      end else begin
        check("frame_error", frame_error, 0);
      end
`endif
    end
  end

  initial begin
    logic [7:0] b;
    wait_cyc(5);
    rst_i = 1'b0;
    wait_cyc(5);

    // 1: single frame 0xA5 at clk/8
    rx_q.delete();
    cs_low();
    send_bits(8'hA5, 8, 4);
    wait_cyc(4);
    cs_high();
    wait_cyc(10);
    check("t1_count", rx_q.size(), 1);
    if (rx_q.size() >= 1) check("t1_word", rx_q[0], 8'hA5);
    check("t1_data_o", data_o, 8'hA5);
    check("t1_busy", busy, 0);
    check("t1_latency", strobe_cyc - last_rise_cyc, 3);

    // 2: three back-to-back bytes under one CS
    rx_q.delete();
    cs_low();
    send_bits(8'h3C, 8, 4);
    send_bits(8'hFF, 8, 4);
    send_bits(8'h00, 8, 4);
    wait_cyc(4);
    cs_high();
    wait_cyc(10);
    check("t2_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check("t2_w0", rx_q[0], 8'h3C);
      check("t2_w1", rx_q[1], 8'hFF);
      check("t2_w2", rx_q[2], 8'h00);
    end

    // 3: partial frame then full 0x81
    rx_q.delete();
    cs_low();
    send_bits(8'hF0, 5, 4);
    wait_cyc(4);
    cs_high();
    wait_cyc(10);
    check("t3_partial_none", rx_q.size(), 0);
    check("t3_hold", data_o, 8'h00);
    cs_low();
    send_bits(8'h81, 8, 4);
    wait_cyc(4);
    cs_high();
    wait_cyc(10);
    check("t3_count", rx_q.size(), 1);
    check("t3_data_o", data_o, 8'h81);
`ifdef SPI_RX_FRAME_ERROR_EN
    check("t3_err_pulses", err_pulses, 1);
    check("t3_err_count", error_count, 1);
    check("t3_err_count_model", error_count, m_err_cnt);
`endif

    // 4: SPI clock activity with CS high is ignored
    rx_q.delete();
    send_bits(8'h55, 8, 4);
    wait_cyc(10);
    check("t4_ignored", rx_q.size(), 0);
    cs_low();
    send_bits(8'h12, 8, 4);
    wait_cyc(4);
    cs_high();
    wait_cyc(10);
    check("t4_count", rx_q.size(), 1);
    check("t4_data_o", data_o, 8'h12);

    // 5: reset mid-frame, CS stays low
    rx_q.delete();
    cs_low();
    send_bits(8'hC3, 4, 4);
    rst_i = 1'b1;
    m_cnt = 0;
    wait_cyc(5);
    check("t5_rst_data", data_o, 0);
    check("t5_rst_busy", busy, 0);
    rst_i = 1'b0;
    wait_cyc(8);
    send_bits(8'h7E, 8, 4);
    wait_cyc(4);
    cs_high();
    wait_cyc(10);
    check("t5_count", rx_q.size(), 1);
    if (rx_q.size() >= 1) check("t5_word", rx_q[0], 8'h7E);
    check("t5_data_o", data_o, 8'h7E);

    // 6: 16 random bytes at the minimum clk/4 ratio
    rx_q.delete();
    sent_q.delete();
    cs_low();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      sent_q.push_back(b);
      send_bits(b, 8, 2);
    end
    wait_cyc(2);
    cs_high();
    wait_cyc(10);
    check("t6_count", rx_q.size(), 16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      check("t6_word", rx_q[i], sent_q[i]);
    end
    check("end_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
